if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 10 +
 rtl/if_fifo.sv | 66 ++++++
 rtl/if_stage.sv | 72 +++++++
 tb/tb_if_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants used by the fetch path and its neighbours.
// No logic here; latency and backpressure are defined by the modules that import it.
// Widths default to RV32.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries for the decode stage.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: a push is dropped when full unless a pop happens on the same edge; flush wins over both.
module if_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A full buffer can still accept when the head leaves on the same edge.
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage is left unreset; count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register driving a combinational imem, buffered into if_fifo.
// Latency: first instruction valid one cycle after reset release or redirect.
// Backpressure: fetch stalls (PC held) while the buffer is full and decode does not pop.
module if_stage
    import riscv_pkg::*;
#(
    parameter int          N        = XLEN,
    parameter logic [N-1:0] RESET_PC = N'(PC_RESET_DEFAULT),
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [N-1:0] inst_out,
    output logic [N-1:0] inst_pc,
    output logic [N-1:0] inst_pc_plus4
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]   pc_q;
    logic           push_en;
    logic           pop_en;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [2*N-1:0] head_dat;
    logic [N-1:0]   head_pc;

    assign imem_addr = pc_q;
    assign pop_en    = inst_valid && inst_ready;
    // Redirect suppresses the push: the word at pc_q is on the wrong path.
    assign push_en   = !redirect_valid && (!fifo_full || pop_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[N-1:2], 2'b00};
        end else if (push_en) begin
            pc_q <= pc_q + N'(4);
        end
    end

    if_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_en),
        .push_dat ({pc_q, imem_rdata}),
        .pop      (pop_en),
        .flush    (redirect_valid),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign inst_valid    = (fifo_count != '0);
    assign head_pc       = head_dat[2*N-1:N];
    assign inst_pc       = fifo_empty ? '0 : head_pc;
    assign inst_out      = fifo_empty ? '0 : head_dat[N-1:0];
    assign inst_pc_plus4 = fifo_empty ? '0 : head_pc + N'(4);

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized checks of if_stage against a queue-based fetch model.
module tb_if_stage;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_pc_plus4;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;

    if_stage #(.N(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Advance the model by one edge using the inputs currently applied, then step the DUT.
    task automatic tick();
        bit pop;
        bit was_full;
        if (rst_n) begin
            pop      = (mq.size() != 0) && inst_ready;
            was_full = (mq.size() == 2);
            if (redirect_valid) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(mq.pop_front());
                if (!was_full || pop) begin
                    mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        mq.delete();
        m_pc           = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        mq.delete();
        m_pc           = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        tick();
        tick();
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
        tests_run++; if (inst_out !== 32'h0) begin tests_failed++; $display("FAIL reset_inst got %h want 0", inst_out); end
        tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want 0", inst_pc); end
        tests_run++; if (inst_pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL reset_pc4 got %h want 0", inst_pc_plus4); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        apply_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d] got %0b want 1", i, inst_valid); end
            tests_run++; if (inst_pc !== 32'(4 * i)) begin tests_failed++; $display("FAIL stream_pc[%0d] got %h want %h", i, inst_pc, 32'(4 * i)); end
            tests_run++; if (inst_out !== 32'(i)) begin tests_failed++; $display("FAIL stream_inst[%0d] got %h want %h", i, inst_out, 32'(i)); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tests_run++; if (imem_addr !== 32'h8) begin tests_failed++; $display("FAIL bp_addr got %h want 8", imem_addr); end
        tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL bp_head_pc got %h want 0", inst_pc); end
        tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid got %0b want 1", inst_valid); end
        inst_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            tests_run++; if (inst_pc !== 32'(4 * i)) begin tests_failed++; $display("FAIL bp_drain_pc[%0d] got %h want %h", i, inst_pc, 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect_full();
        apply_reset();
        inst_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush_valid got %0b want 0", inst_valid); end
        tests_run++; if (imem_addr !== 32'h100) begin tests_failed++; $display("FAIL redir_addr got %h want 100", imem_addr); end
        tick();
        tests_run++; if (inst_pc !== 32'h100) begin tests_failed++; $display("FAIL redir_pc got %h want 100", inst_pc); end
        tests_run++; if (inst_out !== 32'h40) begin tests_failed++; $display("FAIL redir_inst got %h want 40", inst_out); end
    endtask

    task automatic test_wrap();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tests_run++; if (imem_addr !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL wrap_addr got %h want fffffff8", imem_addr); end
        tick();
        tests_run++; if (inst_pc !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL wrap_pc0 got %h want fffffff8", inst_pc); end
        tests_run++; if (inst_out !== 32'h3FFF_FFFE) begin tests_failed++; $display("FAIL wrap_inst0 got %h want 3ffffffe", inst_out); end
        tick();
        tests_run++; if (inst_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc1 got %h want fffffffc", inst_pc); end
        tests_run++; if (inst_pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc4 got %h want 0", inst_pc_plus4); end
        tick();
        tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc2 got %h want 0", inst_pc); end
        tests_run++; if (inst_out !== 32'h0) begin tests_failed++; $display("FAIL wrap_inst2 got %h want 0", inst_out); end
    endtask

    task automatic test_full_pop_push();
        apply_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        inst_ready = 1'b1;
        tick();
        tests_run++; if (inst_pc !== 32'h4) begin tests_failed++; $display("FAIL fpp_head got %h want 4", inst_pc); end
        tests_run++; if (imem_addr !== 32'hC) begin tests_failed++; $display("FAIL fpp_addr got %h want c", imem_addr); end
        inst_ready = 1'b0;
        tick();
        tests_run++; if (inst_pc !== 32'h4) begin tests_failed++; $display("FAIL fpp_hold_head got %h want 4", inst_pc); end
        tests_run++; if (imem_addr !== 32'hC) begin tests_failed++; $display("FAIL fpp_hold_addr got %h want c", imem_addr); end
        inst_ready = 1'b1;
        tick();
        tests_run++; if (inst_pc !== 32'h8) begin tests_failed++; $display("FAIL fpp_next_head got %h want 8", inst_pc); end
        tests_run++; if (inst_out !== 32'h2) begin tests_failed++; $display("FAIL fpp_next_inst got %h want 2", inst_out); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #3;
        rst_n = 1'b0;
        mq.delete();
        m_pc = 32'h0;
        #1;
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_valid got %0b want 0", inst_valid); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL arst_addr got %h want 0", imem_addr); end
        tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL arst_pc got %h want 0", inst_pc); end
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL arst_restart_valid got %0b want 1", inst_valid); end
        tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL arst_restart_pc got %h want 0", inst_pc); end
        tick();
        tests_run++; if (inst_pc !== 32'h4) begin tests_failed++; $display("FAIL arst_restart_pc1 got %h want 4", inst_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_valid;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
            tick();
            exp_valid = (mq.size() != 0);
            exp_pc    = exp_valid ? mq[0].pc : 32'h0;
            exp_inst  = exp_valid ? mq[0].inst : 32'h0;
            tests_run++; if (inst_valid !== exp_valid) begin tests_failed++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, inst_valid, exp_valid); end
            tests_run++; if (inst_pc !== exp_pc) begin tests_failed++; $display("FAIL rnd_pc[%0d] got %h want %h", i, inst_pc, exp_pc); end
            tests_run++; if (inst_out !== exp_inst) begin tests_failed++; $display("FAIL rnd_inst[%0d] got %h want %h", i, inst_out, exp_inst); end
            tests_run++; if (inst_pc_plus4 !== (exp_valid ? exp_pc + 32'd4 : 32'h0)) begin tests_failed++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, inst_pc_plus4, exp_valid ? exp_pc + 32'd4 : 32'h0); end
            tests_run++; if (imem_addr !== m_pc) begin tests_failed++; $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_addr, m_pc); end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_full_pop_push();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests_run);
        $fatal(1);
    end

endmodule
